// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multicycle MULT/DIV sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MULT_RUN  = 3'd1,
        DIV_RUN   = 3'd2,
        WRITEBACK = 3'd3,
        DIVZERO   = 3'd4
    } muldiv_state_t;

    localparam logic HILO_SEL_MULT = 1'b0;
    localparam logic HILO_SEL_DIV  = 1'b1;

    // Counter width large enough to hold max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/op_cycle_counter.sv
// Down-counter for fixed-length iterative operations; reports the first and last cycle.
module op_cycle_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         is_zero_o,
    output logic         is_first_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         first_q, first_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        if (clear_i) begin
            cnt_d   = '0;
            first_d = 1'b0;
        end else if (load_i) begin
            cnt_d   = value_i;
            first_d = 1'b1;
        end else if (dec_i) begin
            first_d = 1'b0;
            // Saturate at zero: the count is reloaded on every entry, never wrapped.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign is_zero_o  = (cnt_q == '0);
    assign is_first_o = first_q;

endmodule

// File: rtl/muldiv_controller.sv
// Moore sequencer that runs the iterative MULT/DIV unit and commits its result to HI/LO.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_is_div,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              op_ready,
    output logic              busy,
    output logic              mult_start,
    output logic              mult_enable,
    output logic              div_start,
    output logic              div_enable,
    output logic              hi_sel,
    output logic              lo_sel,
    output logic              write_hi,
    output logic              write_lo,
    output logic              div_zero,
    output logic              done
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    muldiv_state_t    state_q, state_d;
    logic             op_is_div_q, op_is_div_d;
    logic             accept;
    logic             cnt_clear, cnt_load, cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero, cnt_first;

    op_cycle_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (cnt_clear),
        .load_i    (cnt_load),
        .value_i   (cnt_value),
        .dec_i     (cnt_dec),
        .is_zero_o (cnt_zero),
        .is_first_o(cnt_first)
    );

    assign accept = (state_q == IDLE) && !flush && op_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_is_div_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_is_div_q <= op_is_div_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_is_div_d = op_is_div_q;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_value   = MULT_LOAD;
        cnt_dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_is_div_d = op_is_div;
                    if (!op_is_div) begin
                        state_d  = MULT_RUN;
                        cnt_load = 1'b1;
                    end else if (operand_b != '0) begin
                        state_d   = DIV_RUN;
                        cnt_load  = 1'b1;
                        cnt_value = DIV_LOAD;
                    end else begin
                        state_d = DIVZERO;
                    end
                end
            end
            MULT_RUN, DIV_RUN: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK, DIVZERO: state_d = IDLE;
            default:            state_d = IDLE;
        endcase
        // Abort wins over everything; a committing cycle still emits its outputs below.
        if (flush) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
            cnt_load  = 1'b0;
            cnt_dec   = 1'b0;
        end
    end

    always_comb begin
        op_ready    = 1'b0;
        busy        = 1'b1;
        mult_start  = 1'b0;
        mult_enable = 1'b0;
        div_start   = 1'b0;
        div_enable  = 1'b0;
        hi_sel      = HILO_SEL_MULT;
        lo_sel      = HILO_SEL_MULT;
        write_hi    = 1'b0;
        write_lo    = 1'b0;
        div_zero    = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready = !flush;
                busy     = 1'b0;
            end
            MULT_RUN: begin
                mult_enable = 1'b1;
                mult_start  = cnt_first;
            end
            DIV_RUN: begin
                div_enable = 1'b1;
                div_start  = cnt_first;
            end
            WRITEBACK: begin
                hi_sel   = op_is_div_q ? HILO_SEL_DIV : HILO_SEL_MULT;
                lo_sel   = op_is_div_q ? HILO_SEL_DIV : HILO_SEL_MULT;
                write_hi = 1'b1;
                write_lo = 1'b1;
                done     = 1'b1;
            end
            DIVZERO: begin
                div_zero = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench: a 32/32-cycle instance and a 1/1-cycle instance, latencies checked per cycle.
module tb_muldiv_controller;

    typedef struct packed {
        logic op_ready;
        logic busy;
        logic mult_start;
        logic mult_enable;
        logic div_start;
        logic div_enable;
        logic hi_sel;
        logic lo_sel;
        logic write_hi;
        logic write_lo;
        logic div_zero;
        logic done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid_v [2];
    logic        op_is_div_v[2];
    logic [31:0] operand_b_v[2];
    logic        flush_v    [2];
    obs_t        obs        [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic w_ready, w_busy, w_ms, w_me, w_ds, w_de, w_hs, w_ls, w_wh, w_wl, w_dz, w_done;

        muldiv_controller #(
            .DATA_W     (32),
            .MULT_CYCLES((g == 0) ? 32 : 1),
            .DIV_CYCLES ((g == 0) ? 32 : 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .op_valid   (op_valid_v[g]),
            .op_is_div  (op_is_div_v[g]),
            .operand_b  (operand_b_v[g]),
            .flush      (flush_v[g]),
            .op_ready   (w_ready),
            .busy       (w_busy),
            .mult_start (w_ms),
            .mult_enable(w_me),
            .div_start  (w_ds),
            .div_enable (w_de),
            .hi_sel     (w_hs),
            .lo_sel     (w_ls),
            .write_hi   (w_wh),
            .write_lo   (w_wl),
            .div_zero   (w_dz),
            .done       (w_done)
        );

        assign obs[g] = {w_ready, w_busy, w_ms, w_me, w_ds, w_de,
                         w_hs, w_ls, w_wh, w_wl, w_dz, w_done};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int u, input logic v, input logic d, input logic [31:0] b);
        op_valid_v[u]  = v;
        op_is_div_v[u] = d;
        operand_b_v[u] = b;
    endtask

    // Entered and left at a negedge. Times are cycles after the accepting edge (-1 = never).
    task automatic do_op(input int u, input string tag, input logic is_div,
                         input logic [31:0] b, input int flush_at,
                         input int exp_start_t, input int exp_en, input int exp_done_t,
                         input int exp_wr, input int exp_dz_t, input int exp_ready_t,
                         input logic exp_sel);
        obs_t cur;
        int   t       = 1;
        int   start_t = -1;
        int   start_n = 0;
        int   en_n    = 0;
        int   other_n = 0;
        int   done_t  = -1;
        int   done_n  = 0;
        int   wr_n    = 0;
        int   dz_t    = -1;
        int   ready_t = -1;
        logic [1:0] sel = 2'b00;

        check({tag, ".ready_in"}, 32'(obs[u].op_ready), 32'd1);
        drive(u, 1'b1, is_div, b);
        @(posedge clk);
        @(negedge clk);
        drive(u, 1'b0, 1'b0, 32'd0);
        while (t <= 80) begin
            cur = obs[u];
            if (is_div ? cur.div_start : cur.mult_start) begin
                start_n++;
                start_t = t;
            end
            if (is_div ? cur.div_enable : cur.mult_enable) en_n++;
            if (is_div ? (cur.mult_start | cur.mult_enable) : (cur.div_start | cur.div_enable))
                other_n++;
            if (cur.done) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            if (cur.write_hi | cur.write_lo) begin
                wr_n++;
                sel = {cur.hi_sel, cur.lo_sel};
            end
            if (cur.div_zero && dz_t < 0) dz_t = t;
            if (cur.op_ready) begin
                ready_t = t;
                break;
            end
            if (t == flush_at) flush_v[u] = 1'b1;
            @(posedge clk);
            #1 flush_v[u] = 1'b0;
            @(negedge clk);
            t++;
        end
        check({tag, ".start_t"}, 32'(start_t), 32'(exp_start_t));
        check({tag, ".start_n"}, 32'(start_n), (exp_start_t > 0) ? 32'd1 : 32'd0);
        check({tag, ".en_cycles"}, 32'(en_n), 32'(exp_en));
        check({tag, ".other_unit"}, 32'(other_n), 32'd0);
        check({tag, ".done_t"}, 32'(done_t), 32'(exp_done_t));
        check({tag, ".done_n"}, 32'(done_n), (exp_done_t > 0) ? 32'd1 : 32'd0);
        check({tag, ".wr_cycles"}, 32'(wr_n), 32'(exp_wr));
        check({tag, ".dz_t"}, 32'(dz_t), 32'(exp_dz_t));
        check({tag, ".ready_t"}, 32'(ready_t), 32'(exp_ready_t));
        if (exp_wr > 0) check({tag, ".sel"}, 32'(sel), {30'd0, exp_sel, exp_sel});
    endtask

    obs_t idle_pat;

    initial begin
        idle_pat          = '0;
        idle_pat.op_ready = 1'b1;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            drive(u, 1'b0, 1'b0, 32'd0);
            flush_v[u] = 1'b0;
        end

        // 1. reset held three cycles, then released
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.held", 32'(obs[0]), 32'(idle_pat));
        reset = 1'b0;
        @(negedge clk);
        check("rst.rel0", 32'(obs[0]), 32'(idle_pat));
        check("rst.rel1", 32'(obs[1]), 32'(idle_pat));

        // 2-4. MULT, DIV, DIV by zero on the 32-cycle unit
        do_op(0, "mult32", 1'b0, 32'h1234, -1, 1, 32, 33, 1, -1, 34, 1'b0);
        do_op(0, "div7",   1'b1, 32'd7,    -1, 1, 32, 33, 1, -1, 34, 1'b1);
        do_op(0, "div0",   1'b1, 32'd0,    -1, -1, 0, 1, 0, 1, 2, 1'b0);

        // 5. flush in cycle 10 of a MULT, then an immediate normal MULT
        do_op(0, "mflush", 1'b0, 32'd5, 10, 1, 10, -1, 0, -1, 11, 1'b0);
        do_op(0, "mafter", 1'b0, 32'd6, -1, 1, 32, 33, 1, -1, 34, 1'b0);

        // flush in IDLE blocks accept
        flush_v[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 32'd1);
        #1 check("idle_flush.ready", 32'(obs[0].op_ready), 32'd0);
        @(posedge clk);
        #1 flush_v[0] = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("idle_flush.busy", 32'(obs[0].busy), 32'd0);
        check("idle_flush.ready2", 32'(obs[0].op_ready), 32'd1);

        // 6. async reset mid DIV_RUN, between clock edges
        drive(0, 1'b1, 1'b1, 32'd9);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0);
        repeat (4) @(negedge clk);
        check("arst.running", 32'(obs[0].div_enable), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst.div_en", 32'(obs[0].div_enable), 32'd0);
        check("arst.outs", 32'(obs[0]), 32'(idle_pat));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arst.after", 32'(obs[0]), 32'(idle_pat));
        do_op(0, "b2b_mult", 1'b0, 32'd3, -1, 1, 32, 33, 1, -1, 34, 1'b0);
        do_op(0, "b2b_div",  1'b1, 32'd3, -1, 1, 32, 33, 1, -1, 34, 1'b1);

        // single-cycle run instance
        do_op(1, "c1_mult",  1'b0, 32'd2, -1, 1, 1, 2, 1, -1, 3, 1'b0);
        do_op(1, "c1_div",   1'b1, 32'd3, -1, 1, 1, 2, 1, -1, 3, 1'b1);
        do_op(1, "c1_div0",  1'b1, 32'd0, -1, -1, 0, 1, 0, 1, 2, 1'b0);
        do_op(1, "c1_flush", 1'b0, 32'd4, 1, 1, 1, -1, 0, -1, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
